uart_recv: RTL and testbench

//  8N1 UART receiver; the receiving end of the serial line driven by uart_send.

---
 rtl/uart_recv.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_recv.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// -----------------------------------------------------------------------------
// uart_recv -- 8N1 UART receiver, the receiving end of the uart_send line.
//
// rx_in is synchronised and then sampled 16 times per bit. Each bit is decided
// by a majority vote of the samples taken in slots 7, 8 and 9. Every finished
// frame produces a one-clock strobe: rx_done for a good stop bit, frame_err for
// a low stop bit. The baud index uses the same encoding as uart_send, so both
// ends can share one selector.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   OVERSAMPLE  sample ticks per bit; fixed at 16, do not override
//
// Ports
//   clk_50mhz  in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   baud       in   3  0=9600 1=19200 2=38400 3=57600 4=115200, 5..7=9600
//   rx_in      in   1  serial line, asynchronous to the clock, idles high
//   rx_data    out  8  last correctly framed byte
//   rx_done    out  1  one-clock pulse: rx_data has just been updated
//   frame_err  out  1  one-clock pulse: stop bit sampled low, byte dropped
//   busy       out  1  high from start-bit detection until the frame completes
// -----------------------------------------------------------------------------
module uart_recv #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic [2:0] baud,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV_W      = 16;
  localparam int DIV_9600   = CLK_FREQ / (9600 * OVERSAMPLE);
  localparam int DIV_19200  = CLK_FREQ / (19200 * OVERSAMPLE);
  localparam int DIV_38400  = CLK_FREQ / (38400 * OVERSAMPLE);
  localparam int DIV_57600  = CLK_FREQ / (57600 * OVERSAMPLE);
  localparam int DIV_115200 = CLK_FREQ / (115200 * OVERSAMPLE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Clocks per oversample tick for a baud index; unused codes fall back to 9600.
  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
    logic [DIV_W-1:0] d;
    case (sel)
      3'd0:    d = DIV_W'(DIV_9600);
      3'd1:    d = DIV_W'(DIV_19200);
      3'd2:    d = DIV_W'(DIV_38400);
      3'd3:    d = DIV_W'(DIV_57600);
      3'd4:    d = DIV_W'(DIV_115200);
      default: d = DIV_W'(DIV_9600);
    endcase
    return d;
  endfunction

  // Two-out-of-three vote used to decide every bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic             sync1_r;
  logic             rxs_r;
  logic             rxs_prev_r;
  state_t           state_r;
  state_t           state_n;
  logic [DIV_W-1:0] div_lat_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [3:0]       slot_r;
  logic [2:0]       bit_idx_r;
  logic             samp7_r;
  logic             samp8_r;
  logic [7:0]       shift_r;
  logic [7:0]       rx_data_r;
  logic             rx_done_r;
  logic             frame_err_r;
  logic             busy_r;

  logic             fall_s;
  logic             tick_s;
  logic             maj_s;
  logic             done_set_s;
  logic             err_set_s;

  // A start is only recognised on a real 1->0 transition of the synchronised line.
  assign fall_s = rxs_prev_r & ~rxs_r;
  // The tick runs only inside a frame; the divider is held at zero while idle.
  assign tick_s = (state_r != IDLE) && (div_cnt_r == (div_lat_r - DIV_W'(1)));
  // The slot-9 sample is the live synchronised value, so the vote resolves on that tick.
  assign maj_s  = majority3(samp7_r, samp8_r, rxs_r);

  // Two-flop synchroniser on rx_in plus the delayed copy for edge detection.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r    <= 1'b1;
      rxs_r      <= 1'b1;
      rxs_prev_r <= 1'b1;
    end else begin
      sync1_r    <= rx_in;
      rxs_r      <= sync1_r;
      rxs_prev_r <= rxs_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next-state logic and frame-end strobe requests.
  always_comb begin
    state_n    = state_r;
    done_set_s = 1'b0;
    err_set_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s) begin
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        // A start bit that reads high at mid-bit was only a glitch.
        if (tick_s && (slot_r == 4'd9) && maj_s) begin
          state_n = IDLE;
        end else if (tick_s && (slot_r == 4'd15)) begin
          state_n = DATA;
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (tick_s && (slot_r == 4'd15) && (bit_idx_r == 3'd7)) begin
          state_n = STOP;
        end else begin
          state_n = DATA;
        end
      end
      STOP: begin
        // Leaving at mid-stop lets a back-to-back start edge be caught.
        if (tick_s && (slot_r == 4'd9)) begin
          state_n = IDLE;
          if (maj_s) begin
            done_set_s = 1'b1;
          end else begin
            err_set_s = 1'b1;
          end
        end else begin
          state_n = STOP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Tick divider, slot/bit counters, sample capture and shift register.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      div_lat_r <= DIV_W'(DIV_9600);
      div_cnt_r <= {DIV_W{1'b0}};
      slot_r    <= 4'd0;
      bit_idx_r <= 3'd0;
      samp7_r   <= 1'b1;
      samp8_r   <= 1'b1;
      shift_r   <= 8'h00;
    end else if (state_r == IDLE) begin
      div_cnt_r <= {DIV_W{1'b0}};
      slot_r    <= 4'd0;
      bit_idx_r <= 3'd0;
      // Baud is captured once per frame so a mid-frame change cannot disturb it.
      if (fall_s) begin
        div_lat_r <= baud_div(baud);
      end else begin
        div_lat_r <= div_lat_r;
      end
    end else if (tick_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
      slot_r    <= slot_r + 4'd1;
      case (slot_r)
        4'd7: samp7_r <= rxs_r;
        4'd8: samp8_r <= rxs_r;
        4'd9: begin
          if (state_r == DATA) begin
            shift_r <= {maj_s, shift_r[7:1]};
          end else begin
            shift_r <= shift_r;
          end
        end
        4'd15: begin
          if (state_r == DATA) begin
            bit_idx_r <= bit_idx_r + 3'd1;
          end else begin
            bit_idx_r <= bit_idx_r;
          end
        end
        default: begin
          slot_r <= slot_r + 4'd1;
        end
      endcase
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Registered outputs: strobes and busy change on the same edge as the FSM.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r   <= 8'h00;
      rx_done_r   <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rx_done_r   <= done_set_s;
      frame_err_r <= err_set_s;
      busy_r      <= (state_n != IDLE);
      if (done_set_s) begin
        rx_data_r <= shift_r;
      end else begin
        rx_data_r <= rx_data_r;
      end
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_done   = rx_done_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_recv.sv
// -----------------------------------------------------------------------------
// tb_uart_recv -- self-checking bench for uart_recv.
// A scaled clock (25 MHz) keeps 9600-baud frames short. The serial driver uses
// CLK_FREQ/baud clocks per bit, like the matching transmitter. Each frame pushes
// its expected strobe onto a scoreboard queue; every strobe seen on the DUT pops
// and compares it.
// -----------------------------------------------------------------------------
module tb_uart_recv;

  localparam int CLK_FREQ = 25_000_000;

  logic       clk_50mhz = 1'b0;
  logic       rst_n;
  logic [2:0] baud;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  uart_recv #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .baud      (baud),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #20 clk_50mhz = ~clk_50mhz;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [2:0] baud;
    logic [7:0] data;
    logic       stop;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  function automatic int bit_clks(input logic [2:0] sel);
    case (sel)
      3'd1:    return CLK_FREQ / 19200;
      3'd2:    return CLK_FREQ / 38400;
      3'd3:    return CLK_FREQ / 57600;
      3'd4:    return CLK_FREQ / 115200;
      default: return CLK_FREQ / 9600;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input logic is_err, input logic [7:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    return e;
  endfunction

  // One clock: sample 1 time unit after the edge and score any strobe.
  task automatic step();
    exp_t e;
    @(posedge clk_50mhz);
    #1;
    cyc++;
    if (rx_done || frame_err) begin
      chk("strobe_overlap", 32'(rx_done & frame_err), 32'd0);
      chk("strobe_width", 32'(prev_done | prev_err), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {30'd0, rx_done, frame_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind_frame_err", 32'(frame_err), 32'(e.is_err));
        chk("rx_data_at_strobe", 32'(rx_data), 32'(e.data));
      end
    end
    prev_done = rx_done;
    prev_err  = frame_err;
  endtask

  task automatic wait_clks(input int n);
    for (int k = 0; k < n; k++) begin
      step();
    end
  endtask

  // Drive one 8N1 frame; optionally change the DUT baud select at bit chg_at.
  task automatic send_frame(input int bclk, input logic [7:0] data, input logic stop_val,
                            input int chg_at, input logic [2:0] chg_baud);
    logic [9:0] bits;
    bits = {stop_val, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == chg_at) begin
        baud = chg_baud;
      end
      rx_in = bits[i];
      if (i == 0) begin
        wait_clks(bclk / 2);
        chk("busy_in_start_bit", 32'(busy), 32'd1);
        wait_clks(bclk - bclk / 2);
      end else begin
        wait_clks(bclk);
      end
    end
    rx_in = 1'b1;
  endtask

  // Wait (bounded) until every expected strobe has been seen.
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    wait_clks(16);
    chk({name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int t0;
    int dt;
    logic [9:0] partial;

    vecs[0] = '{3'd0, 8'h55, 1'b1, 1'b0, 8'h55};
    vecs[1] = '{3'd4, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{3'd3, 8'h5A, 1'b1, 1'b0, 8'h5A};
    vecs[3] = '{3'd2, 8'hF0, 1'b0, 1'b1, 8'h5A};
    vecs[4] = '{3'd4, 8'hC7, 1'b1, 1'b0, 8'hC7};

    rst_n = 1'b0;
    baud  = 3'd0;
    rx_in = 1'b1;
    wait_clks(4);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rx_done", 32'(rx_done), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    wait_clks(8);
    chk("idle_busy", 32'(busy), 32'd0);

    // Table: single frames at several baud rates, good and bad stop bits.
    for (int i = 0; i < 5; i++) begin
      baud = vecs[i].baud;
      exp_q.push_back(mk_exp(vecs[i].exp_err, vecs[i].exp_data));
      send_frame(bit_clks(vecs[i].baud), vecs[i].data, vecs[i].stop, -1, 3'd0);
      drain($sformatf("vec%0d_strobe_seen", i), 4 * bit_clks(vecs[i].baud));
      chk($sformatf("vec%0d_rx_data_after", i), 32'(rx_data), 32'(vecs[i].exp_data));
    end

    // Back-to-back frames with a single stop bit at 115200.
    baud = 3'd4;
    exp_q.push_back(mk_exp(1'b0, 8'hA5));
    send_frame(bit_clks(3'd4), 8'hA5, 1'b1, -1, 3'd0);
    exp_q.push_back(mk_exp(1'b0, 8'h3C));
    send_frame(bit_clks(3'd4), 8'h3C, 1'b1, -1, 3'd0);
    drain("b2b_strobes_seen", 4 * bit_clks(3'd4));
    chk("b2b_rx_data", 32'(rx_data), 32'h3C);

    // 150-clock low glitch at 9600: busy must drop near start slot 9, no strobe.
    baud  = 3'd0;
    t0    = cyc;
    rx_in = 1'b0;
    wait_clks(150);
    rx_in = 1'b1;
    chk("glitch_busy_high", 32'(busy), 32'd1);
    dt = 0;
    while (busy && dt < 4000) begin
      step();
      dt++;
    end
    dt = cyc - t0;
    chk("glitch_busy_fall_window", 32'(dt >= 1615 && dt <= 1631), 32'd1);
    wait_clks(bit_clks(3'd0));
    chk("glitch_no_strobe_rx_data", 32'(rx_data), 32'h3C);

    // Reset in the middle of 8'hC3, then a clean 8'h81.
    baud    = 3'd4;
    partial = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx_in = partial[i];
      wait_clks(bit_clks(3'd4));
    end
    chk("midframe_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    rx_in = 1'b1;
    wait_clks(3);
    chk("midreset_rx_data", 32'(rx_data), 32'h00);
    chk("midreset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_clks(12 * bit_clks(3'd4));
    chk("after_reset_rx_data", 32'(rx_data), 32'h00);
    exp_q.push_back(mk_exp(1'b0, 8'h81));
    send_frame(bit_clks(3'd4), 8'h81, 1'b1, -1, 3'd0);
    drain("after_reset_strobe_seen", 4 * bit_clks(3'd4));

    // baud=7 behaves as 9600; switching to 115200 mid-frame must not matter.
    baud = 3'd7;
    exp_q.push_back(mk_exp(1'b0, 8'h6B));
    send_frame(bit_clks(3'd7), 8'h6B, 1'b1, 4, 3'd4);
    drain("baud7_strobe_seen", 4 * bit_clks(3'd0));
    chk("baud7_rx_data", 32'(rx_data), 32'h6B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
